// File: rtl/q100_dtcm_arb.sv
// rtl/q100_dtcm_arb.sv - two-port DTCM arbiter and access sequencer
//
// Shares a single-port, byte-laned DTCM between the core LSU and a DMA/debug
// port. LSU has default priority; a starvation counter forces a DMA grant
// after STARVE_LIMIT consecutive DMA denials. Stores are lane-replicated with
// per-byte enables; loads are realigned and sign/zero-extended. Every grant
// produces exactly one response one cycle later on the winning port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   lsu_*_i / lsu_*_o         LSU request (req, we, addr, size, unsigned,
//                             wdata) and response (gnt, rvalid, rdata, err)
//   dma_*_i / dma_*_o         same set for the DMA/debug port
//   dtcm_addr_o               byte address to the DTCM
//   dtcm_we_o                 per-byte write enables
//   dtcm_data_o               lane-replicated write data
//   dtcm_data_i               DTCM read word, valid the cycle after address

module q100_dtcm_arb #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 12,
   parameter int BANKS        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [1:0]        lsu_size_i,
   input  logic              lsu_unsigned_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              lsu_err_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [1:0]        dma_size_i,
   input  logic              dma_unsigned_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic              dma_err_o,
   output logic [ADDR_W-1:0] dtcm_addr_o,
   output logic [BANKS-1:0]  dtcm_we_o,
   output logic [DATA_W-1:0] dtcm_data_o,
   input  logic [DATA_W-1:0] dtcm_data_i
);

   logic [3:0]        starve_cnt;
   logic              force_dma;
   logic              lsu_win;
   logic              dma_win;
   logic              any_gnt;
   logic              sel_we;
   logic              sel_uns;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_size;
   logic [DATA_W-1:0] sel_wdata;
   logic              mis;

   logic              rsp_lsu;
   logic              rsp_dma;
   logic              rsp_err;
   logic              rsp_load;
   logic [1:0]        rsp_lane;
   logic [1:0]        rsp_size;
   logic              rsp_uns;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [DATA_W-1:0] rd_ext;

   // DMA wins when it is alone or has been denied STARVE_LIMIT times in a row.
   assign force_dma = dma_req_i && (starve_cnt == 4'(STARVE_LIMIT));
   assign dma_win   = !rst && dma_req_i && (!lsu_req_i || force_dma);
   assign lsu_win   = !rst && lsu_req_i && !dma_win;
   assign any_gnt   = lsu_win || dma_win;
   assign lsu_gnt_o = lsu_win;
   assign dma_gnt_o = dma_win;

   always_comb begin
      if (dma_win) begin
         sel_we    = dma_we_i;
         sel_uns   = dma_unsigned_i;
         sel_addr  = dma_addr_i;
         sel_size  = dma_size_i;
         sel_wdata = dma_wdata_i;
      end else begin
         sel_we    = lsu_we_i;
         sel_uns   = lsu_unsigned_i;
         sel_addr  = lsu_addr_i;
         sel_size  = lsu_size_i;
         sel_wdata = lsu_wdata_i;
      end
   end

   assign mis = (sel_size == 2'b11) ||
                (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);

   assign dtcm_addr_o = any_gnt ? sel_addr : '0;

   // Misaligned stores are still granted (so the requester is released) but
   // never touch memory.
   always_comb begin
      dtcm_we_o   = '0;
      dtcm_data_o = '0;
      if (any_gnt && sel_we && !mis) begin
         case (sel_size)
            2'b00: begin
               dtcm_we_o   = BANKS'(1) << sel_addr[1:0];
               dtcm_data_o = {BANKS{sel_wdata[7:0]}};
            end
            2'b01: begin
               dtcm_we_o   = BANKS'(3) << {sel_addr[1], 1'b0};
               dtcm_data_o = {(BANKS/2){sel_wdata[15:0]}};
            end
            default: begin
               dtcm_we_o   = '1;
               dtcm_data_o = sel_wdata;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         rsp_lsu    <= 1'b0;
         rsp_dma    <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_load   <= 1'b0;
         rsp_lane   <= '0;
         rsp_size   <= '0;
         rsp_uns    <= 1'b0;
      end else begin
         if (!dma_req_i || dma_win)
            starve_cnt <= '0;
         else
            starve_cnt <= starve_cnt + 4'd1;
         rsp_lsu  <= lsu_win;
         rsp_dma  <= dma_win;
         rsp_err  <= any_gnt && mis;
         rsp_load <= any_gnt && !sel_we && !mis;
         rsp_lane <= sel_addr[1:0];
         rsp_size <= sel_size;
         rsp_uns  <= sel_uns;
      end
   end

   assign rd_byte = dtcm_data_i[{rsp_lane, 3'b000} +: 8];
   assign rd_half = dtcm_data_i[{rsp_lane[1], 4'b0000} +: 16];

   always_comb begin
      case (rsp_size)
         2'b00:   rd_ext = {{(DATA_W-8){~rsp_uns & rd_byte[7]}}, rd_byte};
         2'b01:   rd_ext = {{(DATA_W-16){~rsp_uns & rd_half[15]}}, rd_half};
         default: rd_ext = dtcm_data_i;
      endcase
   end

   // Gating with rst drops a response whose grant preceded a reset cycle.
   assign lsu_rvalid_o = rsp_lsu && !rst;
   assign dma_rvalid_o = rsp_dma && !rst;
   assign lsu_err_o    = rsp_lsu && rsp_err && !rst;
   assign dma_err_o    = rsp_dma && rsp_err && !rst;
   assign lsu_rdata_o  = (rsp_lsu && rsp_load && !rst) ? rd_ext : '0;
   assign dma_rdata_o  = (rsp_dma && rsp_load && !rst) ? rd_ext : '0;

endmodule

// File: tb/tb_q100_dtcm_arb.sv
// tb/tb_q100_dtcm_arb.sv - self-checking bench for q100_dtcm_arb
module tb_q100_dtcm_arb;

   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu_req = 0, lsu_we = 0, lsu_uns = 0;
   logic [11:0] lsu_addr = 0;
   logic [1:0]  lsu_size = 0;
   logic [31:0] lsu_wdata = 0;
   logic        dma_req = 0, dma_we = 0, dma_uns = 0;
   logic [11:0] dma_addr = 0;
   logic [1:0]  dma_size = 0;
   logic [31:0] dma_wdata = 0;
   logic        lsu_gnt, lsu_rvalid, lsu_err, dma_gnt, dma_rvalid, dma_err;
   logic [31:0] lsu_rdata, dma_rdata, dtcm_data, ram_q;
   logic [11:0] dtcm_addr;
   logic [3:0]  dtcm_we;

   logic [31:0] ram [0:1023];
   logic [7:0]  ref_mem [0:4095];
   int          n_checks = 0;
   int          n_fail = 0;

   logic        s_lgnt, s_dgnt, s_lrv, s_lerr, s_drv, s_derr;
   logic [3:0]  s_we;
   logic [11:0] s_addr;
   logic [31:0] s_data, s_lrd, s_drd;

   always #5 clk = ~clk;

   q100_dtcm_arb #(.DATA_W(32), .ADDR_W(12), .BANKS(4), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr), .lsu_size_i(lsu_size),
      .lsu_unsigned_i(lsu_uns), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
      .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_size_i(dma_size),
      .dma_unsigned_i(dma_uns), .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt),
      .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
      .dtcm_addr_o(dtcm_addr), .dtcm_we_o(dtcm_we), .dtcm_data_o(dtcm_data),
      .dtcm_data_i(ram_q)
   );

   // Single-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (dtcm_we[b]) ram[dtcm_addr[11:2]][8*b +: 8] <= dtcm_data[8*b +: 8];
      ram_q <= ram[dtcm_addr[11:2]];
   end

   // Byte-level reference: returns expected load data, error, lane enables
   // and the data bus value, and applies stores to ref_mem.
   function automatic void model(input logic we, input logic [11:0] a, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic err,
                                 output logic [3:0] wem, output logic [31:0] bus);
      int n;
      n   = 1 << sz;
      rd  = '0;
      wem = '0;
      bus = '0;
      err = (sz == 2'b11) || ((int'(a) % n) != 0);
      if (err) return;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
         for (int b = 0; b < 4; b++) bus[8*b +: 8] = wd[8*(b % n) +: 8];
         for (int i = 0; i < n; i++) wem[(int'(a) % 4) + i] = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[int'(a) + i];
         if (!uns && rd[8*n-1])
            for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
      end
   endfunction

   task automatic set_lsu(input logic r, input logic w, input logic [11:0] a,
                          input logic [1:0] s, input logic u, input logic [31:0] d);
      lsu_req = r; lsu_we = w; lsu_addr = a; lsu_size = s; lsu_uns = u; lsu_wdata = d;
   endtask

   task automatic set_dma(input logic r, input logic w, input logic [11:0] a,
                          input logic [1:0] s, input logic u, input logic [31:0] d);
      dma_req = r; dma_we = w; dma_addr = a; dma_size = s; dma_uns = u; dma_wdata = d;
   endtask

   // One access cycle: request-side outputs are captured at the falling edge,
   // the matching response just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      s_lgnt = lsu_gnt; s_dgnt = dma_gnt; s_we = dtcm_we; s_addr = dtcm_addr; s_data = dtcm_data;
      @(posedge clk);
      #1;
      s_lrv = lsu_rvalid; s_lerr = lsu_err; s_lrd = lsu_rdata;
      s_drv = dma_rvalid; s_derr = dma_err; s_drd = dma_rdata;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_lsu(1, 1, 12'h010, 2'b10, 0, 32'h1234_5678);
      set_dma(1, 1, 12'h020, 2'b10, 0, 32'h8765_4321);
      @(negedge clk);
      n_checks++; if (lsu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_gnt got %b exp 0", lsu_gnt); end
      n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dma_gnt got %b exp 0", dma_gnt); end
      n_checks++; if (dtcm_we !== 4'h0) begin n_fail++; $display("FAIL reset_we got %h exp 0", dtcm_we); end
      n_checks++; if (dtcm_addr !== 12'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", dtcm_addr); end
      n_checks++; if ({lsu_rvalid, dma_rvalid, lsu_err, dma_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rsp got %b exp 0000", {lsu_rvalid, dma_rvalid, lsu_err, dma_err}); end
      n_checks++; if ({lsu_rdata, dma_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {lsu_rdata, dma_rdata}); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_lsu(0, 0, 0, 0, 0, 0);
      set_dma(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_word();
      logic [31:0] e_rd, e_bus;
      logic        e_err;
      logic [3:0]  e_we;
      set_lsu(1, 1, 12'h010, 2'b10, 0, 32'hDEAD_BEEF);
      model(1, 12'h010, 2'b10, 0, 32'hDEAD_BEEF, e_rd, e_err, e_we, e_bus);
      tick();
      n_checks++; if (s_lgnt !== 1'b1) begin n_fail++; $display("FAIL word_st_gnt got %b exp 1", s_lgnt); end
      n_checks++; if (s_we !== 4'hF) begin n_fail++; $display("FAIL word_st_we got %h exp f", s_we); end
      n_checks++; if (s_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_st_data got %h exp deadbeef", s_data); end
      n_checks++; if ({s_lrv, s_lerr, s_lrd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL word_st_rsp got %b %b %h exp 1 0 0", s_lrv, s_lerr, s_lrd); end
      set_lsu(1, 0, 12'h010, 2'b10, 0, 32'h0);
      model(0, 12'h010, 2'b10, 0, 32'h0, e_rd, e_err, e_we, e_bus);
      tick();
      set_lsu(0, 0, 0, 0, 0, 0);
      n_checks++; if (s_we !== 4'h0) begin n_fail++; $display("FAIL word_ld_we got %h exp 0", s_we); end
      n_checks++; if ({s_lrv, s_lerr, s_drv} !== 3'b100) begin n_fail++; $display("FAIL word_ld_valid got %b exp 100", {s_lrv, s_lerr, s_drv}); end
      n_checks++; if (s_lrd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_ld_data got %h exp deadbeef", s_lrd); end
   endtask

   task automatic test_lanes();
      logic        t_dma [5] = '{0, 0, 1, 0, 1};
      logic        t_we  [5] = '{1, 0, 0, 1, 0};
      logic [11:0] t_a   [5] = '{12'h013, 12'h013, 12'h013, 12'h012, 12'h012};
      logic [1:0]  t_sz  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
      logic        t_u   [5] = '{0, 0, 1, 0, 0};
      logic [31:0] t_wd  [5] = '{32'h0000_0080, 0, 0, 32'h0000_8001, 0};
      logic [3:0]  t_ew  [5] = '{4'b1000, 0, 0, 4'b1100, 0};
      logic [31:0] t_ed  [5] = '{32'h8080_8080, 0, 0, 32'h8001_8001, 0};
      logic [31:0] t_er  [5] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0, 32'hFFFF_8001};
      logic [31:0] e_rd, e_bus, got;
      logic        e_err, gv;
      logic [3:0]  e_we;
      for (int i = 0; i < 5; i++) begin
         if (t_dma[i]) begin set_dma(1, t_we[i], t_a[i], t_sz[i], t_u[i], t_wd[i]); set_lsu(0, 0, 0, 0, 0, 0); end
         else          begin set_lsu(1, t_we[i], t_a[i], t_sz[i], t_u[i], t_wd[i]); set_dma(0, 0, 0, 0, 0, 0); end
         model(t_we[i], t_a[i], t_sz[i], t_u[i], t_wd[i], e_rd, e_err, e_we, e_bus);
         tick();
         got = t_dma[i] ? s_drd : s_lrd;
         gv  = t_dma[i] ? s_drv : s_lrv;
         n_checks++; if (s_we !== t_ew[i]) begin n_fail++; $display("FAIL lanes_we[%0d] got %h exp %h", i, s_we, t_ew[i]); end
         n_checks++; if (s_data !== t_ed[i]) begin n_fail++; $display("FAIL lanes_data[%0d] got %h exp %h", i, s_data, t_ed[i]); end
         n_checks++; if (gv !== 1'b1) begin n_fail++; $display("FAIL lanes_rvalid[%0d] got %b exp 1", i, gv); end
         n_checks++; if (got !== t_er[i]) begin n_fail++; $display("FAIL lanes_rdata[%0d] got %h exp %h", i, got, t_er[i]); end
      end
      set_dma(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_misaligned();
      logic [31:0] e_rd, e_bus;
      logic        e_err;
      logic [3:0]  e_we;
      set_lsu(1, 0, 12'h002, 2'b10, 0, 0);
      tick();
      n_checks++; if ({s_lgnt, s_we} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL mis_word_gnt_we got %b %h exp 1 0", s_lgnt, s_we); end
      n_checks++; if ({s_lrv, s_lerr, s_lrd} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL mis_word_rsp got %b %b %h exp 1 1 0", s_lrv, s_lerr, s_lrd); end
      set_lsu(0, 0, 0, 0, 0, 0);
      set_dma(1, 1, 12'h005, 2'b01, 0, 32'h0000_AAAA);
      tick();
      n_checks++; if ({s_dgnt, s_we} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL mis_half_gnt_we got %b %h exp 1 0", s_dgnt, s_we); end
      n_checks++; if ({s_drv, s_derr, s_drd, s_lrv} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL mis_half_rsp got %b %b %h %b exp 1 1 0 0", s_drv, s_derr, s_drd, s_lrv); end
      set_dma(1, 1, 12'h008, 2'b11, 0, 32'hFFFF_FFFF);
      tick();
      n_checks++; if ({s_dgnt, s_we, s_drv, s_derr} !== {1'b1, 4'h0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL mis_rsvd got %b %h %b %b exp 1 0 1 1", s_dgnt, s_we, s_drv, s_derr); end
      set_dma(0, 0, 0, 0, 0, 0);
      set_lsu(1, 0, 12'h004, 2'b10, 0, 0);
      model(0, 12'h004, 2'b10, 0, 0, e_rd, e_err, e_we, e_bus);
      tick();
      n_checks++; if ({s_lerr, s_lrd} !== {e_err, e_rd}) begin n_fail++; $display("FAIL mis_mem_unchanged got %b %h exp %b %h", s_lerr, s_lrd, e_err, e_rd); end
      set_lsu(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] e_rd, e_bus;
      logic        e_err;
      logic [3:0]  e_we;
      set_lsu(1, 0, 12'h010, 2'b10, 0, 0);
      @(negedge clk);
      n_checks++; if (lsu_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got %b exp 1", lsu_gnt); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_dma(1, 1, 12'h030, 2'b10, 0, 32'h5555_5555);
      #1;
      n_checks++; if ({lsu_rvalid, lsu_rdata, lsu_err} !== {1'b0, 32'h0, 1'b0}) begin n_fail++; $display("FAIL rstmid_drop got %b %h %b exp 0 0 0", lsu_rvalid, lsu_rdata, lsu_err); end
      tick();
      n_checks++; if ({s_lgnt, s_dgnt, s_we, s_addr, s_data} !== 50'h0) begin n_fail++; $display("FAIL rstmid_quiet got %b %b %h %h %h exp all 0", s_lgnt, s_dgnt, s_we, s_addr, s_data); end
      n_checks++; if ({s_lrv, s_drv} !== 2'b00) begin n_fail++; $display("FAIL rstmid_rvalid got %b exp 00", {s_lrv, s_drv}); end
      rst = 1'b0;
      set_dma(0, 0, 0, 0, 0, 0);
      model(0, 12'h010, 2'b10, 0, 0, e_rd, e_err, e_we, e_bus);
      tick();
      n_checks++; if ({s_lgnt, s_lrv, s_lrd} !== {1'b1, 1'b1, e_rd}) begin n_fail++; $display("FAIL rstmid_resume got %b %b %h exp 1 1 %h", s_lgnt, s_lrv, s_lrd, e_rd); end
      set_lsu(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_starve();
      logic [31:0] e_rd, e_bus, wd;
      logic        e_err, d_win, w, u;
      logic [3:0]  e_we;
      logic [11:0] a;
      logic [1:0]  sz;
      logic        lp = 0, dp = 0;
      for (int i = 0; i < 27; i++) begin
         if (!lp) begin
            sz = 2'($urandom_range(0, 2)); a = 12'h40 + 12'($urandom_range(0, 15) << sz);
            set_lsu(1, 1'($urandom), a, sz, 1'($urandom), $urandom); lp = 1;
         end
         if (!dp) begin
            sz = 2'($urandom_range(0, 2)); a = 12'h40 + 12'($urandom_range(0, 15) << sz);
            set_dma(1, 1'($urandom), a, sz, 1'($urandom), $urandom); dp = 1;
         end
         d_win = ((i % (LIMIT + 1)) == LIMIT);
         if (d_win) begin w = dma_we; a = dma_addr; sz = dma_size; u = dma_uns; wd = dma_wdata; end
         else       begin w = lsu_we; a = lsu_addr; sz = lsu_size; u = lsu_uns; wd = lsu_wdata; end
         model(w, a, sz, u, wd, e_rd, e_err, e_we, e_bus);
         tick();
         n_checks++; if ({s_lgnt, s_dgnt} !== {~d_win, d_win}) begin n_fail++; $display("FAIL starve_gnt[%0d] got %b%b exp %b%b", i, s_lgnt, s_dgnt, ~d_win, d_win); end
         n_checks++; if ({s_lrv, s_drv} !== {~d_win, d_win}) begin n_fail++; $display("FAIL starve_rvalid[%0d] got %b%b exp %b%b", i, s_lrv, s_drv, ~d_win, d_win); end
         n_checks++; if ((d_win ? s_drd : s_lrd) !== e_rd) begin n_fail++; $display("FAIL starve_rdata[%0d] got %h exp %h", i, d_win ? s_drd : s_lrd, e_rd); end
         if (d_win) dp = 0; else lp = 0;
      end
      set_lsu(0, 0, 0, 0, 0, 0);
      set_dma(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] e_rd, e_bus, wd;
      logic        e_err, el, ed, w, u;
      logic [3:0]  e_we;
      logic [11:0] a, e_addr;
      logic [1:0]  sz;
      logic        lp = 0, dp = 0;
      int          starve = 0;
      for (int i = 0; i < 400; i++) begin
         if (!lp && ($urandom % 3 != 0)) begin
            set_lsu(1, 1'($urandom), 12'($urandom_range(0, 63)), 2'($urandom), 1'($urandom), $urandom); lp = 1;
         end else if (lp && ($urandom % 10 == 0)) lp = 0;
         if (!dp && ($urandom % 3 == 0)) begin
            set_dma(1, 1'($urandom), 12'($urandom_range(0, 63)), 2'($urandom), 1'($urandom), $urandom); dp = 1;
         end else if (dp && ($urandom % 10 == 0)) dp = 0;
         lsu_req = lp;
         dma_req = dp;
         ed = dp && (!lp || starve == LIMIT);
         el = lp && !ed;
         starve = (!dp || ed) ? 0 : starve + 1;
         if (ed) begin w = dma_we; a = dma_addr; sz = dma_size; u = dma_uns; wd = dma_wdata; end
         else    begin w = lsu_we; a = lsu_addr; sz = lsu_size; u = lsu_uns; wd = lsu_wdata; end
         e_rd = 0; e_err = 0; e_we = 0; e_bus = 0; e_addr = 0;
         if (el || ed) begin model(w, a, sz, u, wd, e_rd, e_err, e_we, e_bus); e_addr = a; end
         tick();
         n_checks++; if ({s_lgnt, s_dgnt} !== {el, ed}) begin n_fail++; $display("FAIL rand_gnt[%0d] got %b%b exp %b%b", i, s_lgnt, s_dgnt, el, ed); end
         n_checks++; if ({s_addr, s_we, s_data} !== {e_addr, e_we, e_bus}) begin n_fail++; $display("FAIL rand_bus[%0d] got %h %h %h exp %h %h %h", i, s_addr, s_we, s_data, e_addr, e_we, e_bus); end
         n_checks++; if ({s_lrv, s_lerr, s_lrd} !== {el, el & e_err, el ? e_rd : 32'h0}) begin n_fail++; $display("FAIL rand_lsu_rsp[%0d] got %b %b %h exp %b %b %h", i, s_lrv, s_lerr, s_lrd, el, el & e_err, el ? e_rd : 32'h0); end
         n_checks++; if ({s_drv, s_derr, s_drd} !== {ed, ed & e_err, ed ? e_rd : 32'h0}) begin n_fail++; $display("FAIL rand_dma_rsp[%0d] got %b %b %h exp %b %b %h", i, s_drv, s_derr, s_drd, ed, ed & e_err, ed ? e_rd : 32'h0); end
         if (el) lp = 0;
         if (ed) dp = 0;
      end
      set_lsu(0, 0, 0, 0, 0, 0);
      set_dma(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
      test_reset();
      test_word();
      test_lanes();
      test_misaligned();
      test_reset_mid();
      test_starve();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/q100_dtcm_arb.md
# q100_dtcm_arb

Two-port arbiter and access sequencer in front of the single-port DTCM. It shares the DTCM between the core load/store unit (LSU) and a DMA/debug port, and generates byte-lane write enables and lane-replicated write data from access size and address. It returns aligned, sign/zero-extended read data with a fixed one-cycle response. It sits between the LSU/debug logic and the DTCM RAM (byte-addressed, 4 byte banks, word index = addr[ADDR_W-1:2], 1-cycle read latency).

## Interface
- DATA_W, 32, data width; fixed at 8*BANKS
- ADDR_W, 12, byte address width
- BANKS, 4, byte lanes
- STARVE_LIMIT, 8, consecutive DMA denials before DMA is forced a grant; legal range 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- lsu_req_i  in  1  LSU access request
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  ADDR_W  byte address
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- lsu_unsigned_i  in  1  zero-extend load result; 0 = sign-extend
- lsu_wdata_i  in  DATA_W  store data, right-justified
- lsu_gnt_o  out  1  request accepted this cycle
- lsu_rvalid_o  out  1  response valid, one cycle after grant
- lsu_rdata_o  out  DATA_W  aligned load data
- lsu_err_o  out  1  misaligned/reserved-size error, qualified by rvalid
- dma_req_i, dma_we_i, dma_addr_i, dma_size_i, dma_unsigned_i, dma_wdata_i, dma_gnt_o, dma_rvalid_o, dma_rdata_o, dma_err_o: same as the LSU set, for the DMA/debug port
- dtcm_addr_o  out  ADDR_W  byte address to DTCM
- dtcm_we_o  out  BANKS  per-byte write enables
- dtcm_data_o  out  DATA_W  lane-replicated write data
- dtcm_data_i  in  DATA_W  DTCM read word, valid the cycle after the address

## Operation
- Grant logic is combinational and takes effect in the same cycle. At most one gnt per cycle. No grants while rst=1.
- Default priority is LSU. DMA wins when only DMA requests, or when the force condition holds.
- Starvation counter (4 bits):
  - Increments each cycle dma_req_i=1 and dma_gnt_o=0.
  - Clears on a DMA grant, when dma_req_i=0, or on rst.
  - When the counter equals STARVE_LIMIT, DMA is granted that cycle even if LSU requests. LSU sees gnt=0 and must hold its request.
- Requesters hold req and all attributes until gnt. Deasserting req before gnt is allowed and cancels the request.
- Granted access drives dtcm_addr_o = addr of the winning port. When idle, dtcm_addr_o=0, dtcm_we_o=0 and dtcm_data_o=0.
- Misalignment is defined as: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - A misaligned access is granted but dtcm_we_o stays 0.
  - The response carries err=1 and rdata=0.
- Store lanes, with k=addr[1:0] and h=addr[1]:
  - Byte: data = {4{wdata[7:0]}}, we = 1<<k.
  - Half: data = {2{wdata[15:0]}}, we = 2'b11<<(2h).
  - Word: data = wdata, we = 4'hF.
- Load extraction uses the registered port, addr[1:0], size and unsigned flags:
  - Byte: ext(word[8k+7:8k]).
  - Half: ext(word[16h+15:16h]).
  - Word: the whole word.
- Stores also produce a response, with rvalid=1 and rdata=0, as a completion ack.
- Responses have no backpressure; the requester must accept rvalid.

## Timing
- Cycle N: req and gnt; address and we are presented to the DTCM.
- Cycle N+1: the winning port's rvalid=1, with rdata/err driven from dtcm_data_i and the registered attributes. The other port's rvalid=0.
- Throughput is one access per cycle, sustained. Back-to-back grants to either port are allowed.
- Response-side outputs are registered:
  - rvalid and err are 0 except in the response cycle.
  - rdata is 0 except in a load response cycle.
- Reset values: all rvalid=0, err=0, rdata=0, starvation counter=0. gnt_o=0 and dtcm_we_o=0 while rst=1.
- rst asserted in cycle N+1 after a grant in cycle N: the pending response is dropped (rvalid=0). A write already issued in cycle N is not reversed.
- Read-after-write to the same word on consecutive grants returns the new data, because the DTCM writes at the N edge and reads at N+1.

## Test plan
- Word store then load, LSU: store 0xDEADBEEF @0x010, then load word @0x010 → dtcm_we_o=4'hF; response at N+1 with rdata=0xDEADBEEF, err=0.
- Byte/half lanes: store byte 0x80 @0x013 → we=4'b1000 and data=0x80808080. Signed byte load @0x013 → 0xFFFFFF80; unsigned → 0x00000080. Half load @0x012 of 0x8001xxxx → 0xFFFF8001.
- Misaligned: word load @0x002 and half store @0x005 → gnt=1, dtcm_we_o=0, response err=1, rdata=0, memory unchanged.
- Contention and starvation: LSU and DMA request continuously with STARVE_LIMIT=8 → LSU is granted 8 cycles, DMA is granted the 9th cycle, and the pattern repeats. Exactly one gnt and one rvalid per cycle.
- Reset mid-operation: LSU load granted in cycle N, rst=1 in N+1 → lsu_rvalid_o=0 in N+1. All outputs read 0 and there are no grants while rst=1. Normal operation resumes the cycle after rst falls.
